// File: rtl/prog_tick_timer.sv
// ---------------------------------------------------------------------------
// prog_tick_timer
//
// Programmable pulse timer with prescaler. Each prescaler wrap is a "tick";
// every P ticks the main counter wraps and a one-clock pulse is emitted.
// The timer runs either periodically or as a one-shot. The configuration is
// captured only on i_start, so mid-run changes to the inputs do nothing.
//
// Ports:
//   i_clk       system clock
//   i_rst       synchronous reset, active-high
//   i_start     start/restart strobe, latches i_mode/i_period/i_prescale
//   i_stop      stop strobe, returns to IDLE (wins over i_start)
//   i_mode      0 = periodic, 1 = one-shot
//   i_period    ticks per pulse (0 selects P_RST_PERIOD)
//   i_prescale  clocks per tick minus 1
//   o_pulse     registered one-clock pulse at each period expiry
//   o_busy      high while running
//   o_done      high after a one-shot has expired
//   o_cnt       current main counter value (0 outside RUN)
// ---------------------------------------------------------------------------
module prog_tick_timer #(
  parameter int unsigned P_CNT_W      = 32,
  parameter int unsigned P_PRE_W      = 16,
  parameter int unsigned P_RST_PERIOD = 5_000_000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_mode,
  input  logic [P_CNT_W-1:0] i_period,
  input  logic [P_PRE_W-1:0] i_prescale,
  output logic               o_pulse,
  output logic               o_busy,
  output logic               o_done,
  output logic [P_CNT_W-1:0] o_cnt
);

  localparam logic [P_CNT_W-1:0] DEF_PER  = P_CNT_W'(P_RST_PERIOD);
  localparam logic [P_CNT_W-1:0] CNT_ONE  = P_CNT_W'(1);
  localparam logic [P_PRE_W-1:0] PRE_ONE  = P_PRE_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [P_PRE_W-1:0] r_pre_cnt, pre_cnt_nxt;
  logic [P_CNT_W-1:0] r_cnt, cnt_nxt;
  logic               r_mode, mode_nxt;
  logic [P_PRE_W-1:0] r_pre, pre_nxt;
  logic [P_CNT_W-1:0] r_per, per_nxt;
  logic               r_pulse, pulse_nxt;

  logic tick;
  logic last;

  // A tick only exists while running; IDLE/DONE hold the counters at zero.
  assign tick = (state == S_RUN) && (r_pre_cnt == r_pre);
  // Compare against r_per-1 so the period is exactly P ticks.
  assign last = (r_cnt == r_per - CNT_ONE);

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    pre_cnt_nxt = r_pre_cnt;
    cnt_nxt     = r_cnt;
    mode_nxt    = r_mode;
    pre_nxt     = r_pre;
    per_nxt     = r_per;
    pulse_nxt   = 1'b0;

    if (i_stop) begin
      state_nxt   = S_IDLE;
      pre_cnt_nxt = '0;
      cnt_nxt     = '0;
    end else if (i_start) begin
      // Restart also discards an expiry that lands on this edge.
      state_nxt   = S_RUN;
      pre_cnt_nxt = '0;
      cnt_nxt     = '0;
      mode_nxt    = i_mode;
      pre_nxt     = i_prescale;
      per_nxt     = (i_period == '0) ? DEF_PER : i_period;
    end else begin
      unique case (state)
        S_RUN: begin
          pre_cnt_nxt = tick ? '0 : r_pre_cnt + PRE_ONE;
          if (tick) begin
            if (last) begin
              cnt_nxt   = '0;
              pulse_nxt = 1'b1;
              if (r_mode) state_nxt = S_DONE;
            end else begin
              cnt_nxt = r_cnt + CNT_ONE;
            end
          end
        end
        S_IDLE, S_DONE: begin
          pre_cnt_nxt = '0;
          cnt_nxt     = '0;
        end
        default: begin
          state_nxt   = S_IDLE;
          pre_cnt_nxt = '0;
          cnt_nxt     = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      r_pre_cnt <= '0;
      r_cnt     <= '0;
      r_mode    <= 1'b0;
      r_pre     <= '0;
      r_per     <= '0;
      r_pulse   <= 1'b0;
    end else begin
      state     <= state_nxt;
      r_pre_cnt <= pre_cnt_nxt;
      r_cnt     <= cnt_nxt;
      r_mode    <= mode_nxt;
      r_pre     <= pre_nxt;
      r_per     <= per_nxt;
      r_pulse   <= pulse_nxt;
    end
  end

  assign o_pulse = r_pulse;
  assign o_busy  = (state == S_RUN);
  assign o_done  = (state == S_DONE);
  assign o_cnt   = r_cnt;

endmodule

// File: tb/tb_prog_tick_timer.sv
// ---------------------------------------------------------------------------
// tb_prog_tick_timer
//
// Directed bench for prog_tick_timer. The default period is overridden to 10
// so the i_period==0 case is short. Inputs are driven 1 ns after a rising
// edge and outputs sampled at the same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_prog_tick_timer;

  localparam int CNT_W = 32;
  localparam int PRE_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic             mode;
  logic [CNT_W-1:0] period;
  logic [PRE_W-1:0] prescale;
  logic             pulse;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cnt;

  int total = 0;
  int bad   = 0;

  prog_tick_timer #(
    .P_CNT_W     (CNT_W),
    .P_PRE_W     (PRE_W),
    .P_RST_PERIOD(10)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_stop     (stop),
    .i_mode     (mode),
    .i_period   (period),
    .i_prescale (prescale),
    .o_pulse    (pulse),
    .o_busy     (busy),
    .o_done     (done),
    .o_cnt      (cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a start strobe; it is sampled on the next edge (edge k) and the
  // task returns 1 ns after that edge.
  task automatic do_start(input logic m, input logic [CNT_W-1:0] p, input logic [PRE_W-1:0] s);
    mode     = m;
    period   = p;
    prescale = s;
    start    = 1'b1;
    step(1);
    start    = 1'b0;
  endtask

  initial begin
    int npulse;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    mode = 1'b0; period = '0; prescale = '0;

    // Reset state
    step(2);
    check("rst_pulse", pulse, 0);
    check("rst_busy",  busy,  0);
    check("rst_done",  done,  0);
    check("rst_cnt",   cnt,   0);
    rst = 1'b0;
    step(1);

    // Periodic, P=4, S=0: pulses after k+4, k+8, k+12; cnt 0,1,2,3,0...
    do_start(1'b0, 4, 0);
    check("p4_busy0", busy, 1);
    check("p4_cnt0",  cnt,  0);
    check("p4_pul0",  pulse, 0);
    for (int n = 1; n <= 12; n++) begin
      step(1);
      check("p4_pulse", pulse, (n % 4 == 0) ? 1 : 0);
      check("p4_cnt",   cnt,   n % 4);
    end
    check("p4_busy", busy, 1);

    // Periodic, P=3, S=2: pulse every 9 clocks, cnt steps every 3 clocks
    do_start(1'b0, 3, 2);
    for (int n = 1; n <= 18; n++) begin
      step(1);
      check("p3s2_pulse", pulse, (n % 9 == 0) ? 1 : 0);
      check("p3s2_cnt",   cnt,   (n / 3) % 3);
    end

    // One-shot, P=5, S=0
    do_start(1'b1, 5, 0);
    for (int n = 1; n <= 5; n++) begin
      step(1);
      check("os_pulse", pulse, (n == 5) ? 1 : 0);
    end
    step(1);
    check("os_done",  done,  1);
    check("os_busy",  busy,  0);
    check("os_pulse_off", pulse, 0);
    check("os_cnt",   cnt,   0);
    npulse = 0;
    for (int n = 0; n < 20; n++) begin
      step(1);
      if (pulse) npulse++;
    end
    check("os_no_more", npulse, 0);
    check("os_done_hold", done, 1);

    // Start from DONE reruns the one-shot
    do_start(1'b1, 5, 0);
    check("os2_busy", busy, 1);
    check("os2_done", done, 0);
    step(4);
    check("os2_pre", pulse, 0);
    step(1);
    check("os2_pulse", pulse, 1);
    step(1);
    check("os2_done1", done, 1);

    // Stop in DONE
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("stop_done", done, 0);
    check("stop_busy", busy, 0);

    // P=0 selects the overridden default of 10
    do_start(1'b0, 0, 0);
    for (int n = 1; n <= 20; n++) begin
      step(1);
      check("p0_pulse", pulse, (n % 10 == 0) ? 1 : 0);
    end

    // P=1, S=0: pulse continuously high after the first edge
    do_start(1'b0, 1, 0);
    for (int n = 1; n <= 6; n++) begin
      step(1);
      check("p1_pulse", pulse, 1);
      check("p1_cnt",   cnt,   0);
    end

    // Mid-run change of i_period has no effect
    do_start(1'b0, 4, 0);
    step(2);
    period = 7;
    step(2);
    check("cfg_ignored", pulse, 1);
    step(1);
    check("cfg_cnt", cnt, 1);

    // Restart mid-period: next pulse exactly P clocks after the restart
    do_start(1'b0, 4, 0);
    check("rs_cnt0", cnt, 0);
    for (int n = 1; n <= 4; n++) begin
      step(1);
      check("rs_pulse", pulse, (n == 4) ? 1 : 0);
    end
    step(3);
    check("rs_cnt3", cnt, 3);
    // Restart coinciding with an expiry suppresses that pulse
    do_start(1'b0, 4, 0);
    check("rs_exp_pulse", pulse, 0);
    check("rs_exp_cnt",   cnt,   0);

    // Start and stop together: stop wins
    step(1);
    start = 1'b1;
    stop  = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    check("ss_busy",  busy,  0);
    check("ss_cnt",   cnt,   0);
    check("ss_pulse", pulse, 0);

    // Reset on the expiring edge
    do_start(1'b0, 4, 0);
    step(3);
    check("rx_cnt3", cnt, 3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rx_pulse", pulse, 0);
    check("rx_busy",  busy,  0);
    check("rx_cnt",   cnt,   0);
    step(2);
    check("rx_idle",  busy,  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
